// File: rtl/elliptic_curve_structs_pkg.sv
// Shared types for the affine short-Weierstrass point unit: field size, modulus,
// point type and the add/double sequencer states.
package elliptic_curve_structs;

  localparam int P_WIDTH = 8;
  localparam logic [P_WIDTH-1:0] PRIME = 8'd17;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
    logic               inf;
  } curve_point_t;

  localparam curve_point_t inf_point = '{x: '0, y: '0, inf: 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    MUL_X2,
    INV,
    MUL_S,
    MUL_S2,
    MUL_Y,
    DONE
  } pa_state_t;

endpackage

// File: rtl/ModMul.sv
// Bit-serial interleaved modular multiplier: one operand bit per cycle, MSB first,
// done pulses for one cycle with res valid.
module ModMul #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] PRIME = 8'd17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, a_sh, b_reg;
  logic [WIDTH:0]   dbl, sum;
  logic [WIDTH-1:0] red, nxt;

  // acc < PRIME is kept invariant so each step needs a single conditional subtract
  always_comb begin
    dbl = {acc, 1'b0};
    red = (dbl >= {1'b0, PRIME}) ? dbl[WIDTH-1:0] - PRIME : dbl[WIDTH-1:0];
    sum = {1'b0, red} + (a_sh[WIDTH-1] ? {1'b0, b_reg} : '0);
    nxt = (sum >= {1'b0, PRIME}) ? sum[WIDTH-1:0] - PRIME : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      a_sh  <= '0;
      b_reg <= '0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        cnt   <= CW'(WIDTH);
        acc   <= '0;
        a_sh  <= a;
        b_reg <= b;
      end else if (busy) begin
        acc  <= nxt;
        a_sh <= a_sh << 1;
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
          res  <= nxt;
        end
      end
    end
  end

endmodule

// File: rtl/mod_addsub.sv
// Combinational modular add/subtract over [0, PRIME); operands must already be reduced.
module mod_addsub #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] PRIME = 8'd17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum, dif;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    if (sub)
      y = dif[WIDTH] ? dif[WIDTH-1:0] + PRIME : dif[WIDTH-1:0];
    else
      y = (sum >= {1'b0, PRIME}) ? sum[WIDTH-1:0] - PRIME : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/modular_inverse.sv
// Binary extended-Euclid inverse modulo an odd PRIME; one reduction step per cycle,
// so latency depends on the operand. An input of zero returns zero at once.
module modular_inverse #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] PRIME = 8'd17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  logic             busy;
  logic [WIDTH-1:0] u, v, x1, x2;

  // x/2 mod PRIME; for odd x this is (x + PRIME) / 2 without the carry bit
  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] xh;
    xh = {1'b0, x[WIDTH-1:1]};
    return x[0] ? xh + {1'b0, PRIME[WIDTH-1:1]} + WIDTH'(1) : xh;
  endfunction

  function automatic logic [WIDTH-1:0] msub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    return d[WIDTH] ? d[WIDTH-1:0] + PRIME : d[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      u    <= '0;
      v    <= '0;
      x1   <= '0;
      x2   <= '0;
      done <= 1'b0;
      res  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        u    <= a;
        v    <= PRIME;
        x1   <= WIDTH'(1);
        x2   <= '0;
        busy <= (a != '0);
        if (a == '0) begin
          res  <= '0;
          done <= 1'b1;
        end
      end else if (busy) begin
        if (u == WIDTH'(1)) begin
          res  <= x1;
          done <= 1'b1;
          busy <= 1'b0;
        end else if (v == WIDTH'(1)) begin
          res  <= x2;
          done <= 1'b1;
          busy <= 1'b0;
        end else if (!u[0]) begin
          u  <= u >> 1;
          x1 <= half(x1);
        end else if (!v[0]) begin
          v  <= v >> 1;
          x2 <= half(x2);
        end else if (u >= v) begin
          u  <= u - v;
          x1 <= msub(x1, x2);
        end else begin
          v  <= v - u;
          x2 <= msub(x2, x1);
        end
      end
    end
  end

endmodule

// File: rtl/point_add_double_unit.sv
// Affine point add/double R = P + Q on y^2 = x^3 + A*x + B over GF(PRIME), sharing one
// inverter and one multiplier. Optional perf counters under POINT_ADD_PERF_CNT_EN.
module point_add_double_unit #(
  parameter int               WIDTH   = elliptic_curve_structs::P_WIDTH,
  parameter logic [WIDTH-1:0] PRIME   = elliptic_curve_structs::PRIME,
  parameter logic [WIDTH-1:0] CURVE_A = '0
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_x,
  input  logic [WIDTH-1:0] p_y,
  input  logic             p_inf,
  input  logic [WIDTH-1:0] q_x,
  input  logic [WIDTH-1:0] q_y,
  input  logic             q_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r_x,
  output logic [WIDTH-1:0] r_y,
  output logic             r_inf,
  output logic             r_dbl
`ifdef POINT_ADD_PERF_CNT_EN
  ,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      dbl_cnt
`endif
);

  import elliptic_curve_structs::*;

  pa_state_t state, next_state;
  logic launch, accept;
  logic [WIDTH-1:0] px, py, qx, qy, num, den, inv, s, rx;
  logic pi, qi, is_dbl, eq_x, special;
  logic mul_start, mul_done, inv_start, inv_done;
  logic [WIDTH-1:0] mul_a, mul_b, mul_res, inv_res;
  logic [WIDTH-1:0] dx, dy, y2, x2_2, x2_3, x2_3a, rx_a, rx_b, px_rx, ry;

  assign accept  = in_valid & in_ready;
  assign eq_x    = (px == qx);
  // vertical line (P = -Q) or tangent at a 2-torsion point both give infinity
  assign special = pi | qi | (eq_x & ((py != qy) | (py == '0)));

  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_dx    (.a(px),      .b(qx),      .sub(1'b1), .y(dx));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_dy    (.a(py),      .b(qy),      .sub(1'b1), .y(dy));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_y2    (.a(py),      .b(py),      .sub(1'b0), .y(y2));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_x2_2  (.a(mul_res), .b(mul_res), .sub(1'b0), .y(x2_2));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_x2_3  (.a(x2_2),    .b(mul_res), .sub(1'b0), .y(x2_3));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_x2_3a (.a(x2_3),    .b(CURVE_A), .sub(1'b0), .y(x2_3a));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_rx_a  (.a(mul_res), .b(px),      .sub(1'b1), .y(rx_a));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_rx_b  (.a(rx_a),    .b(qx),      .sub(1'b1), .y(rx_b));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_px_rx (.a(px),      .b(rx),      .sub(1'b1), .y(px_rx));
  mod_addsub #(.WIDTH(WIDTH), .PRIME(PRIME)) u_ry    (.a(mul_res), .b(py),      .sub(1'b1), .y(ry));

  ModMul #(.WIDTH(WIDTH), .PRIME(PRIME)) u_mul (
    .clk(clk), .rst_n(Reset_n), .start(mul_start), .a(mul_a), .b(mul_b),
    .done(mul_done), .res(mul_res)
  );

  modular_inverse #(.WIDTH(WIDTH), .PRIME(PRIME)) u_inv (
    .clk(clk), .rst_n(Reset_n), .start(inv_start), .a(den),
    .done(inv_done), .res(inv_res)
  );

  // launch marks the first cycle of each sub-block state, giving a one-cycle start
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      launch <= 1'b0;
    end else begin
      state  <= next_state;
      launch <= (next_state != state) &&
                (next_state inside {MUL_X2, INV, MUL_S, MUL_S2, MUL_Y});
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (accept) next_state = CLASSIFY;
      CLASSIFY: next_state = special ? DONE : (eq_x ? MUL_X2 : INV);
      MUL_X2:   if (mul_done) next_state = INV;
      INV:      if (inv_done) next_state = MUL_S;
      MUL_S:    if (mul_done) next_state = MUL_S2;
      MUL_S2:   if (mul_done) next_state = MUL_Y;
      MUL_Y:    if (mul_done) next_state = DONE;
      DONE:     if (out_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    inv_start = launch & (state == INV);
    mul_start = launch & (state inside {MUL_X2, MUL_S, MUL_S2, MUL_Y});
    mul_a     = '0;
    mul_b     = '0;
    unique case (state)
      MUL_X2:  begin mul_a = px; mul_b = px;    end
      MUL_S:   begin mul_a = num; mul_b = inv;  end
      MUL_S2:  begin mul_a = s;  mul_b = s;     end
      MUL_Y:   begin mul_a = s;  mul_b = px_rx; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {px, py, qx, qy, pi, qi} <= '0;
      {num, den, inv, s, rx}   <= '0;
      is_dbl <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_inf  <= 1'b0;
      r_dbl  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          px <= p_x; py <= p_y; pi <= p_inf;
          qx <= q_x; qy <= q_y; qi <= q_inf;
        end
        CLASSIFY: begin
          is_dbl <= eq_x;
          num    <= dy;
          den    <= eq_x ? y2 : dx;
          r_dbl  <= 1'b0;
          if (pi) begin
            r_x   <= qi ? '0 : qx;
            r_y   <= qi ? '0 : qy;
            r_inf <= qi;
          end else if (qi) begin
            r_x   <= px;
            r_y   <= py;
            r_inf <= 1'b0;
          end else if (special) begin
            r_x   <= '0;
            r_y   <= '0;
            r_inf <= 1'b1;
          end
        end
        MUL_X2: if (mul_done) num <= x2_3a;
        INV:    if (inv_done) inv <= inv_res;
        MUL_S:  if (mul_done) s   <= mul_res;
        MUL_S2: if (mul_done) rx  <= rx_b;
        MUL_Y:  if (mul_done) begin
          r_x   <= rx;
          r_y   <= ry;
          r_inf <= 1'b0;
          r_dbl <= is_dbl;
        end
        default: ;
      endcase
    end
  end

`ifdef POINT_ADD_PERF_CNT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      run_cnt   <= '0;
      cycle_cnt <= '0;
      dbl_cnt   <= '0;
    end else begin
      if (accept)
        run_cnt <= 32'd1;
      else if (state != IDLE && state != DONE && run_cnt != '1)
        run_cnt <= run_cnt + 32'd1;
      if (next_state == DONE && state != DONE)
        cycle_cnt <= (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
      if (state == MUL_Y && mul_done && is_dbl)
        dbl_cnt <= dbl_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_point_add_double_unit.sv
// Directed bench for point_add_double_unit over GF(17), A=2.
module tb_point_add_double_unit;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       in_valid = 1'b0, p_inf = 1'b0, q_inf = 1'b0, out_ready = 1'b0;
  logic [7:0] p_x = '0, p_y = '0, q_x = '0, q_y = '0;
  logic       in_ready, out_valid, r_inf, r_dbl;
  logic [7:0] r_x, r_y;
  int         n_err = 0, n_chk = 0;
  int         lat;

  point_add_double_unit #(.WIDTH(8), .PRIME(8'd17), .CURVE_A(8'd2)) dut (
    .clk(clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .p_x(p_x), .p_y(p_y), .p_inf(p_inf), .q_x(q_x), .q_y(q_y), .q_inf(q_inf),
    .out_valid(out_valid), .out_ready(out_ready),
    .r_x(r_x), .r_y(r_y), .r_inf(r_inf), .r_dbl(r_dbl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic pi, input logic [7:0] px, input logic [7:0] py,
                       input logic qi, input logic [7:0] qx, input logic [7:0] qy);
    p_inf = pi; p_x = px; p_y = py;
    q_inf = qi; q_x = qx; q_y = qy;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat = cycles after the accept cycle at which out_valid is seen
  task automatic wait_out(output int l);
    l = 1;
    while (!out_valid && l < 400) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r", {r_x, r_y, r_inf, r_dbl}, 0);
    Reset_n = 1'b1;
    @(posedge clk); #1;

    // add (5,1)+(6,3) = (10,6)
    issue(0, 8'd5, 8'd1, 0, 8'd6, 8'd3);
    chk("add_in_ready_low", in_ready, 0);
    wait_out(lat);
    chk("add_out_valid", out_valid, 1);
    chk("add_r", {r_x, r_y}, {8'd10, 8'd6});
    chk("add_flags", {r_inf, r_dbl}, 2'b00);
    in_valid = 1'b1; p_x = 8'd1; p_y = 8'd1; q_x = 8'd2; q_y = 8'd2;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_r", {r_x, r_y, r_inf}, {8'd10, 8'd6, 1'b0});
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_out();
    chk("add_release_valid", out_valid, 0);
    chk("add_release_ready", in_ready, 1);

    // double 2*(5,1) = (6,3)
    issue(0, 8'd5, 8'd1, 0, 8'd5, 8'd1);
    wait_out(lat);
    chk("dbl_out_valid", out_valid, 1);
    chk("dbl_r", {r_x, r_y}, {8'd6, 8'd3});
    chk("dbl_flags", {r_inf, r_dbl}, 2'b01);
    release_out();

    // inverse points: (5,1) + (5,16) = inf
    issue(0, 8'd5, 8'd1, 0, 8'd5, 8'd16);
    wait_out(lat);
    chk("inv_latency", lat, 2);
    chk("inv_r", {r_x, r_y, r_inf, r_dbl}, {8'd0, 8'd0, 1'b1, 1'b0});
    release_out();

    // tangent at y=0 gives inf
    issue(0, 8'd3, 8'd0, 0, 8'd3, 8'd0);
    wait_out(lat);
    chk("y0_latency", lat, 2);
    chk("y0_r", {r_x, r_y, r_inf, r_dbl}, {8'd0, 8'd0, 1'b1, 1'b0});
    release_out();

    // P at infinity
    issue(1, 8'd0, 8'd0, 0, 8'd6, 8'd3);
    wait_out(lat);
    chk("pinf_latency", lat, 2);
    chk("pinf_r", {r_x, r_y, r_inf, r_dbl}, {8'd6, 8'd3, 1'b0, 1'b0});
    release_out();

    // Q at infinity
    issue(0, 8'd10, 8'd6, 1, 8'd0, 8'd0);
    wait_out(lat);
    chk("qinf_latency", lat, 2);
    chk("qinf_r", {r_x, r_y, r_inf, r_dbl}, {8'd10, 8'd6, 1'b0, 1'b0});
    release_out();

    // reset while the inverter is running
    issue(0, 8'd5, 8'd1, 0, 8'd6, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    Reset_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_r", {r_x, r_y, r_inf}, 0);
    @(posedge clk); #1;
    Reset_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 8'd5, 8'd1, 0, 8'd5, 8'd1);
    wait_out(lat);
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_r", {r_x, r_y, r_inf, r_dbl}, {8'd6, 8'd3, 1'b0, 1'b1});
    release_out();
    chk("post_rst_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
